alu_mips_seq: RTL
=================

// Module: alu_mips_seq
// PURPOSE
//  Parametrised sequential successor of the MIPS datapath ALU. Single-cycle logic/arith/shift
//  ops plus iterative MULTU/DIVU writing architectural HI/LO registers, with valid/ready
//  handshakes on input and output. Sits between register read and writeback; a multi-cycle
//  core stalls on in_ready.
// PARAMETERS
//  WIDTH    32  operand/result width (>=8, power of 2)
//  SHAMT_W   5  shift-amount width; must equal log2(WIDTH)
//  CTRL_W    4  control code width
// PORTS
//  clk       in   1        clock, rising edge
//  rst_n     in   1        asynchronous active-low reset
//  in_valid  in   1        operation presented on a/b/shamt/control
//  in_ready  out  1        unit can accept an operation this cycle
//  a         in   WIDTH    operand A (rs)
//  b         in   WIDTH    operand B (rt / immediate)
//  shamt     in   SHAMT_W  shift amount
//  control   in   CTRL_W   operation code (table below)
//  out_valid out  1        outalu/zero valid
//  out_ready in   1        consumer takes result
//  outalu    out  WIDTH    registered result
//  zero      out  1        outalu == 0
//  hi        out  WIDTH    HI register
//  lo        out  WIDTH    LO register
//  busy      out  1        MUL or DIV iteration in progress
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; outalu, hi, lo, counters = 0; out_valid=0, busy=0, zero=1.
//  Codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (unsigned a<b -> 1 else 0), 12 NOR, 5 SLL b<<shamt,
//   3 SRL b>>shamt, 4 SRA b>>>shamt (signed), 10 MFHI, 11 MFLO, 8 MULTU, 9 DIVU; others -> 0.
//  ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
//  Accept: fire = in_valid & in_ready; in_ready = (state==IDLE) & (!out_valid | out_ready).
//  Single-cycle codes: on fire, outalu registered; out_valid=1 next cycle (latency 1).
//  Output hold: out_valid and outalu stable until out_ready=1; out_valid clears on out_ready
//   unless a new op fires in the same cycle (back-to-back throughput 1/cycle).
//  FSM: IDLE -> MUL (code 8) / DIV (code 9) on fire; iterate WIDTH cycles with busy=1;
//   -> DONE: hi/lo written, outalu=lo, out_valid=1; DONE -> IDLE when out_ready=1.
//   MULTU: unsigned shift-add, {hi,lo}=a*b (2*WIDTH bits). Latency WIDTH+1 fire->out_valid.
//   DIVU: restoring, lo=a/b, hi=a%b, unsigned. Latency WIDTH+1.
//   Divide by zero: no trap; lo=all ones, hi=a (natural restoring result), same latency.
//  hi/lo change only on MUL/DIV completion; MFHI/MFLO read values after last completion.
//  Operands captured at fire; a/b/control changes during MUL/DIV are ignored.
//  in_valid while busy: not accepted, in_ready=0, no side effects.
//  zero is combinational from registered outalu.
//  rst_n low mid-MUL/DIV: abort, hi/lo=0, IDLE; no partial result ever appears.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> all outputs zero/idle immediately, zero=1, in_ready=1 after release.
//  2 Single-cycle: ADD 7+(-7) -> outalu=0, zero=1; SUB 5-9 -> 0xFFFFFFFC; SLT 3,5 -> 1;
//    NOR 0,0 -> 0xFFFFFFFF; SRA 0x80000000 shamt 4 -> 0xF8000000; each out_valid 1 cycle after fire.
//  3 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1 after 33 cycles; MFHI -> 0xFFFFFFFE.
//  4 DIVU 100/7 -> lo=14, hi=2; DIVU 100/0 -> lo=0xFFFFFFFF, hi=100; in_ready=0 throughout.
//  5 Backpressure: out_ready=0 for 5 cycles after ADD -> outalu/out_valid held, in_ready=0;
//    out_ready=1 with next in_valid -> back-to-back, one result per cycle.
//  6 rst_n asserted at iteration 10 of MULTU -> hi=lo=0, out_valid never rises, next op correct.

Source files
------------

// File: rtl/alu_mips_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mips_seq
// Brief    : MIPS ALU with single-cycle ops and iterative MULTU/DIVU into HI/LO,
//            valid/ready handshakes on input and output.
// Revision : 1.0
// ============================================================================
module alu_mips_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int CTRL_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [CTRL_W-1:0]  control,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   outalu,
  output logic               zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy
);

  localparam logic [CTRL_W-1:0] c_and   = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] c_or    = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] c_add   = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] c_srl   = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] c_sra   = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] c_sll   = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] c_sub   = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] c_slt   = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] c_multu = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] c_divu  = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] c_mfhi  = CTRL_W'(10);
  localparam logic [CTRL_W-1:0] c_mflo  = CTRL_W'(11);
  localparam logic [CTRL_W-1:0] c_nor   = CTRL_W'(12);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_outalu;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [WIDTH-1:0]     r_opnd;
  logic [SHAMT_W-1:0]   r_cnt;

  logic                 w_fire;
  logic                 w_last;
  logic                 w_is_muldiv;
  logic [WIDTH-1:0]     w_res;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_div_shift;
  logic [WIDTH-1:0]     w_div_diff;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_iter_hi;
  logic [WIDTH-1:0]     w_iter_lo;

  assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_fire      = in_valid && in_ready;
  assign w_is_muldiv = (control == c_multu) || (control == c_divu);
  assign w_last      = (r_cnt == {SHAMT_W{1'b1}});

  assign out_valid = r_out_valid;
  assign outalu    = r_outalu;
  assign zero      = (r_outalu == '0);
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = (r_state == S_MUL) || (r_state == S_DIV);

  always_comb begin
    w_res = '0;
    case (control)
      c_and:   w_res = a & b;
      c_or:    w_res = a | b;
      c_add:   w_res = a + b;
      c_sub:   w_res = a - b;
      c_slt:   w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      c_nor:   w_res = ~(a | b);
      c_sll:   w_res = b << shamt;
      c_srl:   w_res = b >> shamt;
      c_sra:   w_res = $signed(b) >>> shamt;
      c_mfhi:  w_res = r_hi;
      c_mflo:  w_res = r_lo;
      default: w_res = '0;
    endcase
  end

  // Multiply: acc_lo holds the multiplier, product shifts in from the top.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;

  always_comb begin
    w_iter_hi = w_mul_sum[WIDTH:1];
    w_iter_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
    if (r_state == S_DIV) begin
      w_iter_hi = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
      w_iter_lo = {r_acc_lo[WIDTH-2:0], w_div_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fire && control == c_multu)     w_state_nxt = S_MUL;
        else if (w_fire && control == c_divu) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_DONE;
      S_DONE:       if (out_ready) w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_outalu    <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
      r_opnd      <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            if (w_is_muldiv) begin
              r_acc_hi    <= '0;
              r_acc_lo    <= (control == c_multu) ? b : a;
              r_opnd      <= (control == c_multu) ? a : b;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
            end else begin
              r_outalu    <= w_res;
              r_out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MUL, S_DIV: begin
          r_acc_hi <= w_iter_hi;
          r_acc_lo <= w_iter_lo;
          r_cnt    <= r_cnt + SHAMT_W'(1);
          if (w_last) begin
            r_hi        <= w_iter_hi;
            r_lo        <= w_iter_lo;
            r_outalu    <= w_iter_lo;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: if (out_ready) r_out_valid <= 1'b0;
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire
